clock_phase_generator: RTL and testbench

Master-clock sequencer that produces the phase-select codes CGPP/CGPPN, CGQP/CGQPN and CGRP/CGRPN, plus the gating strobe BOP, consumed by the W/X/Y/Z clock drivers. It divides the oscillator into four equal phases per bit time (W, X, Y, Z) and counts bit times within a cycle. It also provides run, halt and single-step control for the simulated computer.

---
 rtl/clock_phase_generator.sv | 147 ++++++++++++++
 tb/tb_clock_phase_generator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clock_phase_generator.sv
// clock_phase_generator
// Master-clock sequencer. Splits each bit time into four equal phases
// (W, X, Y, Z), produces the P/Q/R phase-select codes and their complements,
// a BOP strobe that is low while the codes settle, and bit/cycle counters.
// Run, halt and single-step control decide whether the sequencer advances.
module clock_phase_generator #(
  parameter int unsigned PHASE_TICKS = 4,   // CLK cycles per phase, 2..15
  parameter int unsigned GAP_TICKS   = 1,   // BOP-low cycles at phase start
  parameter int unsigned BITS        = 14   // bit times per cycle, 2..16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       RUN,
  input  logic       STEP,
  output logic       CGPP,
  output logic       CGPPN,
  output logic       CGQP,
  output logic       CGQPN,
  output logic       CGRP,
  output logic       CGRPN,
  output logic       BOP,
  output logic [1:0] PHASE,
  output logic [3:0] BIT,
  output logic       BIT_END,
  output logic       CYCLE_END,
  output logic       HALTED
);

  // Sequencer states
  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  localparam logic [3:0] TC_MAX  = 4'(PHASE_TICKS - 1);
  localparam logic [3:0] TC_GAP  = 4'(GAP_TICKS);
  localparam logic [3:0] BIT_MAX = 4'(BITS - 1);

  localparam logic [1:0] PH_W = 2'd0;
  localparam logic [1:0] PH_Z = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] tc_q, tc_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] bit_q, bit_d;

  logic       halted_q, halted_d;
  logic       bop_q, bop_d;
  logic       bit_end_q, bit_end_d;
  logic       cycle_end_q, cycle_end_d;
  logic [2:0] code_q, code_d;     // {P, Q, R}

  // P/Q/R pattern for a phase; adjacent phases differ in P and one of Q/R.
  function automatic logic [2:0] phase_code(input logic [1:0] ph);
    case (ph)
      2'd0:    phase_code = 3'b111;  // W
      2'd1:    phase_code = 3'b010;  // X
      2'd2:    phase_code = 3'b100;  // Y
      default: phase_code = 3'b001;  // Z
    endcase
  endfunction

  // Next-state logic: sequencer state, tick/phase/bit counters.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    case (state_q)
      ST_HALT: begin
        tc_d    = 4'd0;
        phase_d = PH_W;
        if (RUN)       state_d = ST_RUN;
        else if (STEP) state_d = ST_STEP;
      end
      ST_RUN, ST_STEP: begin
        if (tc_q == TC_MAX) begin
          tc_d = 4'd0;
          if (phase_q == PH_Z) begin
            // Bit boundary: the only point where the sequencer may stop.
            phase_d = PH_W;
            bit_d   = (bit_q == BIT_MAX) ? 4'd0 : bit_q + 4'd1;
            state_d = RUN ? ST_RUN : ST_HALT;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end else begin
          tc_d = tc_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_HALT;
        tc_d    = 4'd0;
        phase_d = PH_W;
      end
    endcase
  end

  // Output decode from next state, so every output comes straight from a flop.
  always_comb begin
    halted_d    = (state_d == ST_HALT);
    bop_d       = !halted_d && (tc_d >= TC_GAP);
    bit_end_d   = !halted_d && (phase_d == PH_Z) && (tc_d == TC_MAX);
    cycle_end_d = bit_end_d && (bit_d == BIT_MAX);
    code_d      = phase_code(phase_d);
  end

  // State and output registers; reset abandons any partial bit.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_HALT;
      tc_q        <= 4'd0;
      phase_q     <= PH_W;
      bit_q       <= 4'd0;
      halted_q    <= 1'b1;
      bop_q       <= 1'b0;
      bit_end_q   <= 1'b0;
      cycle_end_q <= 1'b0;
      code_q      <= 3'b111;
    end else begin
      state_q     <= state_d;
      tc_q        <= tc_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      halted_q    <= halted_d;
      bop_q       <= bop_d;
      bit_end_q   <= bit_end_d;
      cycle_end_q <= cycle_end_d;
      code_q      <= code_d;
    end
  end

  assign CGPP      = code_q[2];
  assign CGQP      = code_q[1];
  assign CGRP      = code_q[0];
  assign CGPPN     = ~code_q[2];
  assign CGQPN     = ~code_q[1];
  assign CGRPN     = ~code_q[0];
  assign BOP       = bop_q;
  assign PHASE     = phase_q;
  assign BIT       = bit_q;
  assign BIT_END   = bit_end_q;
  assign CYCLE_END = cycle_end_q;
  assign HALTED    = halted_q;

endmodule

// File: tb/tb_clock_phase_generator.sv
// tb_clock_phase_generator
// Directed bench for clock_phase_generator: one instance with default
// parameters (run, wrap, mid-bit halt, single step, reset) and one with
// PHASE_TICKS=2, GAP_TICKS=1, BITS=3 (short bits, cycle wrap, halt).
// Outputs are packed into a 16-bit vector and compared against values
// derived from the cycle count since the sequencer left HALT.
module tb_clock_phase_generator;

  logic clk;
  int   n_compared;
  int   n_mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: defaults ----------------
  logic       rst_n_a, run_a, step_a;
  logic       cgpp_a, cgppn_a, cgqp_a, cgqpn_a, cgrp_a, cgrpn_a;
  logic       bop_a, bit_end_a, cycle_end_a, halted_a;
  logic [1:0] phase_a;
  logic [3:0] bit_a;
  logic [15:0] obs_a;

  clock_phase_generator u_dut_a (
    .CLK(clk), .RESET_N(rst_n_a), .RUN(run_a), .STEP(step_a),
    .CGPP(cgpp_a), .CGPPN(cgppn_a), .CGQP(cgqp_a), .CGQPN(cgqpn_a),
    .CGRP(cgrp_a), .CGRPN(cgrpn_a), .BOP(bop_a), .PHASE(phase_a),
    .BIT(bit_a), .BIT_END(bit_end_a), .CYCLE_END(cycle_end_a),
    .HALTED(halted_a)
  );

  assign obs_a = {halted_a, phase_a, bit_a, bop_a, bit_end_a, cycle_end_a,
                  cgpp_a, cgqp_a, cgrp_a, cgppn_a, cgqpn_a, cgrpn_a};

  // ---------------- instance B: short sequence ----------------
  logic       rst_n_b, run_b, step_b;
  logic       cgpp_b, cgppn_b, cgqp_b, cgqpn_b, cgrp_b, cgrpn_b;
  logic       bop_b, bit_end_b, cycle_end_b, halted_b;
  logic [1:0] phase_b;
  logic [3:0] bit_b;
  logic [15:0] obs_b;

  clock_phase_generator #(.PHASE_TICKS(2), .GAP_TICKS(1), .BITS(3)) u_dut_b (
    .CLK(clk), .RESET_N(rst_n_b), .RUN(run_b), .STEP(step_b),
    .CGPP(cgpp_b), .CGPPN(cgppn_b), .CGQP(cgqp_b), .CGQPN(cgqpn_b),
    .CGRP(cgrp_b), .CGRPN(cgrpn_b), .BOP(bop_b), .PHASE(phase_b),
    .BIT(bit_b), .BIT_END(bit_end_b), .CYCLE_END(cycle_end_b),
    .HALTED(halted_b)
  );

  assign obs_b = {halted_b, phase_b, bit_b, bop_b, bit_end_b, cycle_end_b,
                  cgpp_b, cgqp_b, cgrp_b, cgppn_b, cgqpn_b, cgrpn_b};

  // Counts one comparison and reports it when it disagrees.
  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Expected vector while halted (also the reset vector when b == 0).
  function automatic logic [15:0] exp_halt(input logic [3:0] b);
    exp_halt = {1'b1, 2'd0, b, 3'b000, 3'b111, 3'b000};
  endfunction

  // Expected vector n edges after leaving HALT, starting at bit b0.
  // Code table: W=111, X=010, Y=100, Z=001.
  function automatic logic [15:0] exp_active(input int pt, input int gap,
                                             input int bits, input int n,
                                             input int b0);
    int         tc, ph, bn;
    logic       bop, be, ce;
    logic [2:0] code;
    tc  = n % pt;
    ph  = (n / pt) % 4;
    bn  = (b0 + n / (4 * pt)) % bits;
    bop = (tc >= gap);
    be  = (ph == 3) && (tc == pt - 1);
    ce  = be && (bn == bits - 1);
    case (ph)
      0:       code = 3'b111;
      1:       code = 3'b010;
      2:       code = 3'b100;
      default: code = 3'b001;
    endcase
    exp_active = {1'b0, 2'(ph), 4'(bn), bop, be, ce, code, ~code};
  endfunction

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n_a = 1'b0; run_a = 1'b0; step_a = 1'b0;
    rst_n_b = 1'b0; run_b = 1'b0; step_b = 1'b0;

    // Reset state
    tick(); tick();
    check("a_reset", obs_a, exp_halt(4'd0));
    rst_n_a = 1'b1;
    tick();
    check("a_idle", obs_a, exp_halt(4'd0));

    // Free run through a full cycle wrap, then drop RUN in phase X of bit 5
    run_a = 1'b1;
    for (int n = 0; n < 320; n++) begin
      tick();
      check($sformatf("a_run_n%0d", n), obs_a, exp_active(4, 1, 14, n, 0));
      if (n == 309) run_a = 1'b0;
    end
    tick();
    check("a_halt_bit6", obs_a, exp_halt(4'd6));
    tick();
    check("a_halt_hold", obs_a, exp_halt(4'd6));

    // Single step from bit 6; a second STEP pulse mid-bit is ignored
    step_a = 1'b1;
    tick();
    step_a = 1'b0;
    check("a_step_n0", obs_a, exp_active(4, 1, 14, 0, 6));
    for (int n = 1; n < 16; n++) begin
      tick();
      check($sformatf("a_step_n%0d", n), obs_a, exp_active(4, 1, 14, n, 6));
      if (n == 4) step_a = 1'b1;
      if (n == 5) step_a = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("a_step_halt%0d", i), obs_a, exp_halt(4'd7));
    end

    // STEP with RUN: RUN wins and the sequencer free-runs past the bit
    run_a  = 1'b1;
    step_a = 1'b1;
    tick();
    step_a = 1'b0;
    check("a_both_n0", obs_a, exp_active(4, 1, 14, 0, 7));
    for (int n = 1; n <= 22; n++) begin
      tick();
      check($sformatf("a_both_n%0d", n), obs_a, exp_active(4, 1, 14, n, 7));
    end

    // Asynchronous reset mid-phase X with RUN still high
    rst_n_a = 1'b0;
    #1;
    check("a_async_reset", obs_a, exp_halt(4'd0));
    run_a = 1'b0;
    rst_n_a = 1'b1;

    // Instance B: 8-cycle bits, 3 bits per cycle
    check("b_reset", obs_b, exp_halt(4'd0));
    rst_n_b = 1'b1;
    tick();
    check("b_idle", obs_b, exp_halt(4'd0));
    run_b = 1'b1;
    for (int n = 0; n < 56; n++) begin
      tick();
      check($sformatf("b_run_n%0d", n), obs_b, exp_active(2, 1, 3, n, 0));
      if (n == 55) run_b = 1'b0;
    end
    tick();
    check("b_halt_bit1", obs_b, exp_halt(4'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
